vmmul_unit: RTL
===============

# vmmul_unit

Multi-cycle 4x4 integer matrix-multiply engine for the vector extension. It sits between the vector register file read ports and its write port, alongside the single-cycle vector ALU. It captures the two source matrices when a vector-mmul instruction issues and computes C = A x B, one element per cycle. It then returns the result matrix with a one-cycle write strobe, holding the core with a stall signal while it works.

## Interface
- ELEM_W, 32, element width in bits; a row is 4*ELEM_W = 128 bits.
- LANES, 4, matrix dimension; only 4 is supported.

Ports: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start_i  input  1  vector-mmul instruction issued (is_vector_mmul from control unit).
- rd_addr_i  input  5  destination vector register.
- mat_a_i  input  [4][128]  matrix A, row r = mat_a_i[r], element k at bits [32k+31:32k].
- mat_b_i  input  [4][128]  matrix B, same layout.
- stall_o  output  1  hold PC/fetch (combinational).
- busy_o  output  1  engine not IDLE (registered).
- done_o  output  1  one-cycle completion pulse.
- wr_en_o  output  1  vector register file write enable.
- wr_addr_o  output  5  destination register for write.
- result_o  output  [4][128]  matrix C, same layout, registered.

## Operation
- States: IDLE, COMPUTE, WRITE.
- IDLE: if start_i is high, capture mat_a_i, mat_b_i and rd_addr_i into internal registers, clear the result registers, clear idx to 0, and go to COMPUTE. Otherwise stay in IDLE.
- COMPUTE: idx is a 4-bit counter. Row i = idx[3:2], column j = idx[1:0].
  - Each cycle: C[i][j] <= sum over k=0..3 of A[i][k]*B[k][j], using 4 signed multipliers and an adder tree.
  - Products and sum are truncated to the low 32 bits (two's-complement wrap); no saturation and no flags.
  - When idx reaches 15, write the last element and go to WRITE. Otherwise increment idx.
- WRITE: wr_en_o=1, done_o=1, wr_addr_o = captured rd_addr. Always go to IDLE next.
- start_i is ignored in COMPUTE and WRITE. The issuing instruction is still present during WRITE and must not retrigger.
- Operands are captured, so rd_addr equal to rs1 or rs2, and rs1 equal to rs2, are legal and give the correct result.
- Input changes after capture have no effect.
- result_o holds its value after WRITE until the next start clears it.

## Timing
- Reset values: state IDLE, idx 0, result_o all zero, wr_addr_o 0, busy_o 0, done_o 0, wr_en_o 0, stall_o 0 (while start_i=0).
- stall_o = (state==IDLE & start_i) | (state==COMPUTE). It is low in WRITE, so the PC advances on the same edge that the register file commits C.
- With start_i sampled high in IDLE at edge of cycle T:
  - COMPUTE occupies cycles T+1..T+16.
  - WRITE is cycle T+17.
  - IDLE resumes at T+18.
- Latency from issue to write strobe is 17 cycles; each mmul occupies the engine for 18 cycles.
- busy_o is high in cycles T+1..T+17.
- done_o and wr_en_o are high only in cycle T+17.
- Back-to-back: a new start_i is accepted at the earliest in cycle T+18.
- Reset mid-operation: reset has priority on any edge.
  - Abort to IDLE and clear result_o.
  - No wr_en_o or done_o pulse is produced for the aborted operation.

## Test plan
- Identity: A=I (diagonal 1), B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, rd=3 -> at T+17, wr_en_o=1, wr_addr_o=3, result_o==B; stall_o high T..T+16, low at T+17.
- General: A=B=rows {1,2,3,4}..{13,14,15,16} -> C row0={90,100,110,120}, row3={426,484,542,600}; done_o is a single-cycle pulse.
- Signed/wrap: A[0][0]=0x7FFFFFFF, B[0][0]=2, all other elements 0 -> C[0][0]=0xFFFFFFFE. A[1][1]=-3, B[1][1]=5 -> C[1][1]=0xFFFFFFF1.
- start_i held high through WRITE and beyond -> exactly one wr_en_o pulse per 18-cycle window. Drop start_i at T+17 -> no second operation.
- Operand change after capture: drive mat_a_i to random values from T+1 -> result still matches the captured operands.
- Reset at T+8 -> state IDLE and busy_o=0 on the next cycle, result_o=0, no wr_en_o at T+17. A fresh start then completes normally.

Source files
------------

// File: rtl/vmmul_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : vmmul_unit_if
// Description : Issue/operand/writeback bundle between the vector pipeline and
//               the 4x4 matrix-multiply engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface vmmul_unit_if #(
    parameter int ELEM_W = 32,
    parameter int LANES  = 4
);
    logic                               start_i;
    logic [4:0]                         rd_addr_i;
    logic [LANES-1:0][LANES*ELEM_W-1:0] mat_a_i;
    logic [LANES-1:0][LANES*ELEM_W-1:0] mat_b_i;
    logic                               stall_o;
    logic                               busy_o;
    logic                               done_o;
    logic                               wr_en_o;
    logic [4:0]                         wr_addr_o;
    logic [LANES-1:0][LANES*ELEM_W-1:0] result_o;

    // Core side: issues the instruction and consumes the writeback
    modport master (
        output start_i, rd_addr_i, mat_a_i, mat_b_i,
        input  stall_o, busy_o, done_o, wr_en_o, wr_addr_o, result_o
    );

    // Engine side
    modport slave (
        input  start_i, rd_addr_i, mat_a_i, mat_b_i,
        output stall_o, busy_o, done_o, wr_en_o, wr_addr_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/vmmul_unit.sv
`default_nettype none
// ============================================================================
// Module      : vmmul_unit
// Description : Multi-cycle 4x4 integer matrix multiply C = A x B. Operands are
//               captured on issue, one element of C is produced per cycle with
//               four signed multipliers and an adder tree, and the result is
//               returned with a single-cycle register-file write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vmmul_unit #(
    parameter int ELEM_W = 32,
    parameter int LANES  = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    vmmul_unit_if.slave bus
);
    localparam int         c_ROW_W    = LANES * ELEM_W;
    localparam logic [3:0] c_LAST_IDX = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t                      r_state;
    logic [3:0]                  r_idx;
    logic [LANES-1:0][c_ROW_W-1:0] r_mat_a;
    logic [LANES-1:0][c_ROW_W-1:0] r_mat_b;
    logic [LANES-1:0][c_ROW_W-1:0] r_result;
    logic [4:0]                  r_rd_addr;
    logic [4:0]                  r_wr_addr;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_wr_en;

    logic [1:0]                  w_row;
    logic [1:0]                  w_col;
    logic [ELEM_W-1:0]           w_prod [LANES];
    logic [ELEM_W-1:0]           w_sum_lo;
    logic [ELEM_W-1:0]           w_sum_hi;
    logic [ELEM_W-1:0]           w_sum;

    // Element index walks C row-major: upper bits pick the row, lower the column
    assign w_row = r_idx[3:2];
    assign w_col = r_idx[1:0];

    // One multiplier per k; only the low ELEM_W bits of each product are kept,
    // which is identical for signed and unsigned operands
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_mul
            logic signed [ELEM_W-1:0] w_a_elem;
            logic signed [ELEM_W-1:0] w_b_elem;
            assign w_a_elem  = r_mat_a[w_row][k*ELEM_W +: ELEM_W];
            assign w_b_elem  = r_mat_b[k][w_col*ELEM_W +: ELEM_W];
            assign w_prod[k] = w_a_elem * w_b_elem;
        end
    endgenerate

    // Two-level adder tree, wrapping at ELEM_W bits
    assign w_sum_lo = w_prod[0] + w_prod[1];
    assign w_sum_hi = w_prod[2] + w_prod[3];
    assign w_sum    = w_sum_lo + w_sum_hi;

    // Sequencer: capture on issue, one element per cycle, then a single write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_mat_a   <= '0;
            r_mat_b   <= '0;
            r_result  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_mat_a   <= bus.mat_a_i;
                        r_mat_b   <= bus.mat_b_i;
                        r_rd_addr <= bus.rd_addr_i;
                        r_result  <= '0;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_result[w_row][w_col*ELEM_W +: ELEM_W] <= w_sum;
                    if (r_idx == c_LAST_IDX) begin
                        r_done    <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_rd_addr;
                        r_state   <= S_WRITE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_WRITE: begin
                    // The issuing instruction may still be asserting start here;
                    // it is ignored so the same instruction never retriggers
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall drops in WRITE so the PC advances on the same edge C is committed
    assign bus.stall_o   = ((r_state == S_IDLE) && bus.start_i) || (r_state == S_COMPUTE);
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.wr_en_o   = r_wr_en;
    assign bus.wr_addr_o = r_wr_addr;
    assign bus.result_o  = r_result;

endmodule
`default_nettype wire
